serial_ripple_subtractor: RTL

- Bit-serial counterpart of the team's 4-bit parallel ripple-carry adder. Computes A − B − Bin over WIDTH clock cycles using a single full-subtractor cell and a borrow flip-flop.
- Used as the inverse-operation block, and as an area-minimal arithmetic unit next to the parallel adder.
- Start/busy/done handshake. Result is held until the next operation.

---
 rtl/serial_ripple_subtractor_pkg.sv | 19 +
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_ripple_subtractor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/serial_ripple_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_ripple_subtractor_pkg
// Description : Shared state encodings and default operand width for the
//               serial subtractor and its parallel-adder sibling.
// Revision    : 1.0  initial release
// ============================================================================
package serial_ripple_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_ripple_subtractor_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Single-bit combinational full subtractor (a - b - bin), the
//               borrow mirror of the adder's full-adder cell.
// Revision    : 1.0  initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_ripple_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_ripple_subtractor
// Description : Bit-serial A - B - Bin using one full-subtractor cell and a
//               borrow flop, LSB first, with start/busy/done handshake.
//               Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
// Revision    : 1.0  initial release
// ============================================================================
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Ovf,
`endif
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               bit_a;
    logic               bit_b;
    logic               bit_d;
    logic               bit_bo;
    logic [WIDTH-1:0]   res_shifted;

    assign bit_a       = a_q[cnt_q];
    assign bit_b       = b_q[cnt_q];
    assign res_shifted = {bit_d, res_q[WIDTH-1:1]};

    full_subtractor u_full_subtractor (
        .a    (bit_a),
        .b    (bit_b),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bo)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d = res_shifted;
                br_d  = bit_bo;
                cnt_d = cnt_q + 1'b1;
                // Results are loaded with the final bit so they are already
                // valid during the DONE cycle that carries the done pulse.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    diff_d  = res_shifted;
                    bout_d  = bit_bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (bit_a ^ bit_b) & (bit_a ^ bit_d);
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf  = ovf_q;
`endif
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule : serial_ripple_subtractor
`default_nettype wire
